jtag_host: RTL

- JTAG initiator (host) that drives TCK/TMS/TDI and samples TDO: the host end of the UProc JTAG TAP port.
- Placed in the dev chassis so on-board logic can reset the TAP and shift IR/DR through GPIO_0[3:0] without an external probe.
- Accepts commands over a valid/ready interface, runs the IEEE 1149.1 state walk, and returns the captured TDO bits.

---
 rtl/jtag_host_pkg.sv | 48 ++++
 rtl/jtag_host_if.sv | 30 +++
 rtl/jtag_host_tckgen.sv | 50 +++++
 rtl/jtag_host.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/jtag_host_pkg.sv
// jhost_pkg: shared opcodes, FSM states and TMS walk tables for the JTAG host.
package jhost_pkg;

    typedef enum logic [1:0] {
        OP_TAP_RESET = 2'b00,
        OP_SHIFT_IR  = 2'b01,
        OP_SHIFT_DR  = 2'b10,
        OP_RSVD      = 2'b11
    } jhost_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SHIFT,
        ST_POST,
        ST_DONE
    } jhost_state_e;

    // Prefix walks from Run-Test/Idle (or any state, for reset), LSB is sent first.
    localparam int         PRE_LEN_DR    = 3;
    localparam int         PRE_LEN_IR    = 4;
    localparam int         PRE_LEN_RESET = 6;
    localparam logic [2:0] PRE_TMS_DR    = 3'b001;
    localparam logic [3:0] PRE_TMS_IR    = 4'b0011;
    localparam logic [5:0] PRE_TMS_RESET = 6'b011111;

    // Exit1 -> Update -> Run-Test/Idle takes two TCKs after the last shift bit.
    localparam int         POST_LEN      = 2;

    function automatic logic [2:0] pre_last(input jhost_op_e op);
        case (op)
            OP_SHIFT_DR: return 3'(PRE_LEN_DR - 1);
            OP_SHIFT_IR: return 3'(PRE_LEN_IR - 1);
            default:     return 3'(PRE_LEN_RESET - 1);
        endcase
    endfunction

    function automatic logic pre_tms(input jhost_op_e op, input logic [2:0] idx);
        logic [7:0] pat;
        case (op)
            OP_SHIFT_DR: pat = {5'b00000, PRE_TMS_DR};
            OP_SHIFT_IR: pat = {4'b0000, PRE_TMS_IR};
            default:     pat = {2'b00, PRE_TMS_RESET};
        endcase
        return pat[idx];
    endfunction

endpackage

// File: rtl/jtag_host_if.sv
// jtag_host_if: command/response handshake plus the four JTAG pins of the host.
interface jtag_host_if #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
    logic               jhost_cmdValid_i;
    logic               jhost_cmdReady_o;
    logic [1:0]         jhost_cmdOp_i;
    logic [LEN_W-1:0]   jhost_cmdLen_i;
    logic [MAX_LEN-1:0] jhost_cmdData_i;
    logic               jhost_rspValid_o;
    logic [MAX_LEN-1:0] jhost_rspData_o;
    logic               jhost_busy_o;
    logic               jhost_tck_o;
    logic               jhost_tms_o;
    logic               jhost_tdi_o;
    logic               jhost_tdo_i;

    modport slave (
        input  jhost_cmdValid_i, jhost_cmdOp_i, jhost_cmdLen_i, jhost_cmdData_i, jhost_tdo_i,
        output jhost_cmdReady_o, jhost_rspValid_o, jhost_rspData_o, jhost_busy_o,
               jhost_tck_o, jhost_tms_o, jhost_tdi_o
    );

    modport master (
        output jhost_cmdValid_i, jhost_cmdOp_i, jhost_cmdLen_i, jhost_cmdData_i, jhost_tdo_i,
        input  jhost_cmdReady_o, jhost_rspValid_o, jhost_rspData_o, jhost_busy_o,
               jhost_tck_o, jhost_tms_o, jhost_tdi_o
    );
endinterface

// File: rtl/jtag_host_tckgen.sv
// jhost_tckgen: divides clk into TCK (low phase first) and flags the edges that
// will raise and lower TCK so the FSM can sample TDO and advance TMS/TDI.
module jhost_tckgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    output logic tck_o,
    output logic fall_strobe_o,
    output logic rise_strobe_o
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tck_q, tck_d;
    logic             phase_end;

    // Count out each half period; disabling parks TCK low with the counter cleared.
    always_comb begin
        phase_end = en && (cnt_q == CNT_W'(CLK_DIV - 1));
        cnt_d     = '0;
        tck_d     = 1'b0;
        if (en) begin
            if (phase_end) begin
                cnt_d = '0;
                tck_d = ~tck_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                tck_d = tck_q;
            end
        end
    end

    // Divider state register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end

    assign tck_o         = tck_q;
    assign rise_strobe_o = phase_end && !tck_q;
    assign fall_strobe_o = phase_end && tck_q;

endmodule

// File: rtl/jtag_host.sv
// jtag_host: JTAG initiator. Takes TAP_RESET/SHIFT_IR/SHIFT_DR commands, walks the
// TAP from Run-Test/Idle through the shift and back, and returns captured TDO bits.
module jtag_host
    import jhost_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input logic        jhost_clk,
    input logic        jhost_rstn,
    jtag_host_if.slave bus
);
    localparam int IDX_W = (LEN_W > 3) ? LEN_W : 3;
    localparam int SEL_W = $clog2(MAX_LEN);

    jhost_state_e       state_q, state_d;
    jhost_op_e          op_q, op_d;
    logic [LEN_W-1:0]   last_q, last_d;
    logic [MAX_LEN-1:0] data_q, data_d;
    logic [MAX_LEN-1:0] cap_q, cap_d;
    logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic               ready_q;
    logic               tck, fall_stb, rise_stb, tck_en, cmd_ready, accept;

    function automatic logic [LEN_W-1:0] eff_last(input logic [LEN_W-1:0] len);
        if (len == '0)                   return '0;
        else if (len > LEN_W'(MAX_LEN))  return LEN_W'(MAX_LEN - 1);
        else                             return len - LEN_W'(1);
    endfunction

    assign tck_en    = (state_q == ST_PRE) || (state_q == ST_SHIFT) || (state_q == ST_POST);
    assign cmd_ready = ready_q && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign accept    = cmd_ready && bus.jhost_cmdValid_i;

    jhost_tckgen #(.CLK_DIV(CLK_DIV)) u_tckgen (
        .clk           (jhost_clk),
        .rstn          (jhost_rstn),
        .en            (tck_en),
        .tck_o         (tck),
        .fall_strobe_o (fall_stb),
        .rise_strobe_o (rise_stb)
    );

    // Walk the phases one TCK at a time, capture TDO on rising TCK, and line up
    // TMS/TDI for the next period whenever a new low phase is about to start.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        last_d     = last_q;
        data_d     = data_q;
        cap_d      = cap_q;
        rsp_data_d = rsp_data_q;
        idx_d      = idx_q;
        tms_d      = tms_q;
        tdi_d      = tdi_q;

        case (state_q)
            ST_PRE: begin
                if (fall_stb) begin
                    if (idx_q == IDX_W'(pre_last(op_q))) begin
                        state_d = (op_q == OP_TAP_RESET) ? ST_DONE : ST_SHIFT;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_SHIFT: begin
                if (rise_stb) begin
                    cap_d[idx_q[SEL_W-1:0]] = bus.jhost_tdo_i;
                end
                if (fall_stb) begin
                    if (idx_q == IDX_W'(last_q)) begin
                        state_d = ST_POST;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_POST: begin
                if (fall_stb) begin
                    if (idx_q == IDX_W'(POST_LEN - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            op_d    = jhost_op_e'(bus.jhost_cmdOp_i);
            last_d  = eff_last(bus.jhost_cmdLen_i);
            data_d  = bus.jhost_cmdData_i;
            cap_d   = '0;
            idx_d   = '0;
            state_d = (jhost_op_e'(bus.jhost_cmdOp_i) == OP_RSVD) ? ST_DONE : ST_PRE;
        end

        if (state_d == ST_DONE) begin
            rsp_data_d = cap_d;
        end

        if (accept || fall_stb) begin
            case (state_d)
                ST_PRE: begin
                    tms_d = pre_tms(op_d, idx_d[2:0]);
                    tdi_d = 1'b0;
                end
                ST_SHIFT: begin
                    tms_d = (idx_d == IDX_W'(last_d));
                    tdi_d = data_d[idx_d[SEL_W-1:0]];
                end
                ST_POST: begin
                    tms_d = (idx_d == '0);
                    tdi_d = 1'b0;
                end
                default: begin
                    tms_d = 1'b0;
                    tdi_d = 1'b0;
                end
            endcase
        end
    end

    // Command and pin state; reset parks the TAP pins with TMS high.
    always_ff @(posedge jhost_clk) begin
        if (!jhost_rstn) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_TAP_RESET;
            last_q     <= '0;
            data_q     <= '0;
            cap_q      <= '0;
            rsp_data_q <= '0;
            idx_q      <= '0;
            tms_q      <= 1'b1;
            tdi_q      <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            last_q     <= last_d;
            data_q     <= data_d;
            cap_q      <= cap_d;
            rsp_data_q <= rsp_data_d;
            idx_q      <= idx_d;
            tms_q      <= tms_d;
            tdi_q      <= tdi_d;
            ready_q    <= 1'b1;
        end
    end

    assign bus.jhost_cmdReady_o = cmd_ready;
    assign bus.jhost_busy_o     = tck_en;
    assign bus.jhost_rspValid_o = (state_q == ST_DONE);
    assign bus.jhost_rspData_o  = rsp_data_q;
    assign bus.jhost_tck_o      = tck;
    assign bus.jhost_tms_o      = tms_q;
    assign bus.jhost_tdi_o      = tdi_q;

endmodule
